// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : CPU, external and memory-side signal bundle of the memory arbiter.
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_stall;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters and the memory model sit on the master side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_rdata, ext_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    // The arbiter itself.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_rdata, ext_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Two-requester arbiter (CPU / external) in front of the unified
//            MIPS memory with fixed-latency issue/wait/response sequencing.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic       c_SKIP_WAIT    = (WAIT_CYCLES == 0);
    localparam logic [3:0] c_WAIT_LAST    = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [3:0] c_STARVE_MAX   = 4'hF;

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_starve;
    logic [3:0]        r_wait_cnt;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ext_rdata;

    logic w_any_req;
    logic w_grant_ext;
    logic w_wait_done;
    logic w_capture;

    assign w_any_req   = bus.cpu_req | bus.ext_req;
    // CPU has priority unless ext has already been passed over STARVE_LIMIT times.
    assign w_grant_ext = bus.ext_req & (~bus.cpu_req | (r_starve == c_STARVE_LIMIT));
    assign w_wait_done = (r_wait_cnt == c_WAIT_LAST);

    // Read data is sampled on the last cycle before RESP.
    generate
        if (WAIT_CYCLES == 0) begin : g_no_wait
            assign w_capture = (r_state == c_ISSUE) & ~r_we;
        end else begin : g_wait
            assign w_capture = (r_state == c_WAIT) & w_wait_done & ~r_we;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_starve   <= 4'd0;
            r_wait_cnt <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_state <= c_ISSUE;
                        r_owner <= w_grant_ext;
                        r_we    <= w_grant_ext ? bus.ext_we    : bus.cpu_we;
                        r_addr  <= w_grant_ext ? bus.ext_addr  : bus.cpu_addr;
                        r_wdata <= w_grant_ext ? bus.ext_wdata : bus.cpu_wdata;
                    end
                    if (!bus.ext_req || w_grant_ext) begin
                        r_starve <= 4'd0;
                    end else if (r_starve != c_STARVE_MAX) begin
                        r_starve <= r_starve + 4'd1;
                    end
                end
                c_ISSUE: begin
                    r_state    <= c_SKIP_WAIT ? c_RESP : c_WAIT;
                    r_wait_cnt <= 4'd0;
                end
                c_WAIT: begin
                    if (w_wait_done) begin
                        r_state    <= c_RESP;
                        r_wait_cnt <= 4'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_rdata <= '0;
            r_ext_rdata <= '0;
        end else if (w_capture) begin
            if (r_owner) begin
                r_ext_rdata <= bus.mem_rdata;
            end else begin
                r_cpu_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = (r_state == c_ISSUE);
    assign bus.mem_we    = (r_state == c_ISSUE) & r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    assign bus.cpu_ready = (r_state == c_RESP) & ~r_owner;
    assign bus.ext_ready = (r_state == c_RESP) &  r_owner;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.ext_rdata = r_ext_rdata;
    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ready;

endmodule
`default_nettype wire
